// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM state encoding and
// instruction field positions.
package cpu_defs;

  localparam logic [3:0] OP_LD   = 4'd0;
  localparam logic [3:0] OP_ST   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam int OP_MSB  = 19;
  localparam int OP_LSB  = 16;
  localparam int RA_LSB  = 11;
  localparam int RB_LSB  = 6;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multi-cycle CPU. MUL exists only when CPU_MUL_EN
// is defined; otherwise no multiplier is built.
module cpu_alu
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = a;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
`ifdef CPU_MUL_EN
      OP_MUL: result = a * b;
`endif
      default: result = a;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer, register file,
// req/valid instruction fetch and req/ack data access. Optional MUL: CPU_MUL_EN.
module multicycle_cpu
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_ADDR_BITS = 5,
  parameter int MEM_ADDR_BITS = 5,
  parameter int PC_BITS       = 8,
  parameter int INSTR_WIDTH   = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [PC_BITS-1:0]       imem_addr,
  input  logic                     imem_valid,
  input  logic [INSTR_WIDTH-1:0]   imem_data,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [MEM_ADDR_BITS-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  input  logic                     dmem_ack,
  output logic                     retire,
  output logic                     halted
);

  if (INSTR_WIDTH != 20) begin : g_bad_instr_width
    $error("multicycle_cpu: INSTR_WIDTH must be 20");
  end

  state_t                   state, next_state;
  logic [PC_BITS-1:0]       pc, pc_off, pc_next;
  logic [INSTR_WIDTH-1:0]   ir;
  logic [3:0]               op, alu_op;
  logic [REG_ADDR_BITS-1:0] ra, rb;
  logic [DATA_WIDTH-1:0]    imm_d, a_val, b_val, alu_b, alu_y, result;
  logic                     writes_reg, is_mem_op, halt_pulse;
  logic [DATA_WIDTH-1:0]    regs [2**REG_ADDR_BITS];

  function automatic logic [DATA_WIDTH-1:0] sext_data(input logic signed [IMM_W-1:0] v);
    return DATA_WIDTH'(v);
  endfunction

  function automatic logic [PC_BITS-1:0] sext_pc(input logic signed [IMM_W-1:0] v);
    return PC_BITS'(v);
  endfunction

  assign op        = ir[OP_MSB:OP_LSB];
  assign ra        = ir[RA_LSB +: REG_ADDR_BITS];
  assign rb        = ir[RB_LSB +: REG_ADDR_BITS];
  assign imm_d     = sext_data(ir[IMM_MSB:IMM_LSB]);
  assign pc_off    = sext_pc(ir[IMM_MSB:IMM_LSB]);
  assign is_mem_op = (op == OP_LD) || (op == OP_ST);
  assign imem_addr = pc;

  // ADDI reuses the adder with the sign-extended immediate as second operand
  assign alu_op = (op == OP_ADDI) ? OP_ADD : op;
  assign alu_b  = (op == OP_ADDI) ? imm_d : b_val;

  cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op    (alu_op),
    .a     (a_val),
    .b     (alu_b),
    .result(alu_y)
  );

  always_comb begin
    writes_reg = 1'b0;
    case (op)
      OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: writes_reg = 1'b1;
`ifdef CPU_MUL_EN
      OP_MUL: writes_reg = 1'b1;
`endif
      default: writes_reg = 1'b0;
    endcase
  end

  always_comb begin
    pc_next = pc + PC_BITS'(1);
    case (op)
      OP_BEQ:  if (a_val == b_val) pc_next = pc + pc_off;
      OP_JMP:  pc_next = pc + pc_off;
      default: pc_next = pc + PC_BITS'(1);
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (imem_valid) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        if (is_mem_op)          next_state = S_MEM;
        else if (op == OP_HALT) next_state = S_HALT;
        else                    next_state = S_WB;
      end
      S_MEM:    if (dmem_ack) next_state = S_WB;
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  // Fetch request is gated by rst so it stays low while reset is held
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    halted   = 1'b0;
    retire   = 1'b0;
    case (state)
      S_FETCH: imem_req = !rst;
      S_MEM:   dmem_req = 1'b1;
      S_WB:    retire   = 1'b1;
      S_HALT: begin
        halted = 1'b1;
        retire = halt_pulse;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halt_pulse <= 1'b0;
    end else begin
      state      <= next_state;
      halt_pulse <= (state == S_EXEC) && (next_state == S_HALT);
      if (state == S_EXEC && is_mem_op) begin
        dmem_we    <= (op == OP_ST);
        dmem_addr  <= MEM_ADDR_BITS'(b_val + imm_d);
        dmem_wdata <= a_val;
      end
      if (state == S_MEM && dmem_ack) dmem_we <= 1'b0;
      if (state == S_WB) pc <= pc_next;
    end
  end

  // Datapath registers and register file carry no reset
  always_ff @(posedge clk) begin
    if (state == S_FETCH && imem_valid) ir <= imem_data;
    if (state == S_DECODE) begin
      a_val <= regs[ra];
      b_val <= regs[rb];
    end
    if (state == S_EXEC) result <= alu_y;
    if (state == S_MEM && dmem_ack && !dmem_we) result <= dmem_rdata;
    if (state == S_WB && writes_reg) regs[ra] <= result;
  end

endmodule
